// File: rtl/rst_seq_ctrl_if.sv
// Signal bundle between the reset sequencer and the per-domain clock gates / reset fan-out.
// The sequencer takes the slave side of this interface; its stimulus source takes the master side.
interface rst_seq_ctrl_if #(
  parameter int NUM_DOM   = 4,
  parameter int STAGGER_W = 8
);
  logic                 en_i;
  logic [STAGGER_W-1:0] stagger_i;
  logic [NUM_DOM-1:0]   dom_req_i;
  logic [NUM_DOM-1:0]   clk_en_o;
  logic [NUM_DOM-1:0]   rst_no;
  logic                 busy_o;
  logic                 done_o;

  modport master (
    output en_i, stagger_i, dom_req_i,
    input  clk_en_o, rst_no, busy_o, done_o
  );

  modport slave (
    input  en_i, stagger_i, dom_req_i,
    output clk_en_o, rst_no, busy_o, done_o
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Brings NUM_DOM domains out of reset in index order (clock enable, then reset release S cycles later),
// services per-domain soft resets in RUN and performs an orderly shutdown when en_i drops.
module rst_seq_ctrl #(
  parameter int NUM_DOM   = 4,
  parameter int STAGGER_W = 8,
  parameter int HOLD_CYC  = 4
) (
  input  logic          ref_clk_i,
  input  logic          glob_arst_ni,
  rst_seq_ctrl_if.slave bus
);
  localparam int HOLD_W = $clog2(HOLD_CYC + 1);
  localparam int CNT_W  = (STAGGER_W > HOLD_W) ? STAGGER_W : HOLD_W;
  localparam int IDX_W  = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
  localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(HOLD_CYC);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DOM - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLK_ON  = 3'd1,
    S_RST_OFF = 3'd2,
    S_RUN     = 3'd3,
    S_FLUSH   = 3'd4
  } state_e;

  state_e                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [STAGGER_W-1:0]            stag_q, stag_d;
  logic [NUM_DOM-1:0]              soft_act_q, soft_act_d;
  logic [NUM_DOM-1:0][CNT_W-1:0]   soft_cnt_q, soft_cnt_d;
  logic [NUM_DOM-1:0]              clk_en_q, clk_en_d;
  logic [NUM_DOM-1:0]              rst_n_q, rst_n_d;
  logic                            busy_q, busy_d;
  logic                            done_q, done_d;
  logic                            stag_hit_s, flush_hit_s;

  assign stag_hit_s  = (cnt_q == (CNT_W'(stag_q) - CNT_W'(1)));
  assign flush_hit_s = (cnt_q == (HOLD_TERM - CNT_W'(1)));

  // State register, datapath registers and registered outputs
  always_ff @(posedge ref_clk_i) begin
    if (!glob_arst_ni) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      stag_q     <= '0;
      soft_act_q <= '0;
      soft_cnt_q <= '0;
      clk_en_q   <= '0;
      rst_n_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      stag_q     <= stag_d;
      soft_act_q <= soft_act_d;
      soft_cnt_q <= soft_cnt_d;
      clk_en_q   <= clk_en_d;
      rst_n_q    <= rst_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state and stagger/flush counter; en_i low always wins over staying up
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    stag_d  = stag_q;
    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        cnt_d = '0;
        if (bus.en_i) begin
          state_d = S_CLK_ON;
          stag_d  = (bus.stagger_i == '0) ? STAGGER_W'(1) : bus.stagger_i;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLK_ON, S_RST_OFF: begin
        if (!bus.en_i) begin
          state_d = S_FLUSH;
          cnt_d   = '0;
        end else if (stag_hit_s) begin
          cnt_d = '0;
          if (state_q == S_CLK_ON) begin
            state_d = S_RST_OFF;
          end else if (idx_q == LAST_IDX) begin
            state_d = S_RUN;
          end else begin
            state_d = S_CLK_ON;
            idx_d   = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        cnt_d = '0;
        if (!bus.en_i) begin
          state_d = S_FLUSH;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FLUSH: begin
        if (flush_hit_s) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Per-domain soft reset: low from the request for max(HOLD_CYC, request length) cycles
  always_comb begin
    soft_act_d = '0;
    soft_cnt_d = '0;
    for (int k = 0; k < NUM_DOM; k++) begin
      if ((state_q == S_RUN) && bus.en_i) begin
        if (!soft_act_q[k]) begin
          if (bus.dom_req_i[k]) begin
            soft_act_d[k] = 1'b1;
            soft_cnt_d[k] = CNT_W'(1);
          end else begin
            soft_act_d[k] = 1'b0;
            soft_cnt_d[k] = '0;
          end
        end else begin
          soft_cnt_d[k] = (soft_cnt_q[k] == HOLD_TERM) ? HOLD_TERM : (soft_cnt_q[k] + CNT_W'(1));
          soft_act_d[k] = bus.dom_req_i[k] || (soft_cnt_q[k] != HOLD_TERM);
        end
      end else begin
        soft_act_d[k] = 1'b0;
        soft_cnt_d[k] = '0;
      end
    end
  end

  // Output decode from the current state; registered one edge later
  always_comb begin
    clk_en_d = '0;
    rst_n_d  = '0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        clk_en_d = '0;
      end
      S_CLK_ON: begin
        busy_d = 1'b1;
        for (int j = 0; j < NUM_DOM; j++) begin
          clk_en_d[j] = (IDX_W'(j) <= idx_q);
          rst_n_d[j]  = (IDX_W'(j) < idx_q);
        end
      end
      S_RST_OFF: begin
        busy_d = 1'b1;
        for (int j = 0; j < NUM_DOM; j++) begin
          clk_en_d[j] = (IDX_W'(j) <= idx_q);
          rst_n_d[j]  = (IDX_W'(j) <= idx_q);
        end
      end
      S_RUN: begin
        clk_en_d = '1;
        rst_n_d  = ~soft_act_q;
        done_d   = 1'b1;
      end
      S_FLUSH: begin
        clk_en_d = clk_en_q;
        busy_d   = 1'b1;
      end
      default: begin
        clk_en_d = '0;
      end
    endcase
  end

  assign bus.clk_en_o = clk_en_q;
  assign bus.rst_no   = rst_n_q;
  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: timeline-based reference model compared every cycle, directed literal
// expectations for the documented scenarios, then a long randomized run.
module tb_rst_seq_ctrl;
  localparam int N    = 4;
  localparam int SW   = 8;
  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rstn;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  rst_seq_ctrl_if #(.NUM_DOM(N), .STAGGER_W(SW)) bus ();

  rst_seq_ctrl #(.NUM_DOM(N), .STAGGER_W(SW), .HOLD_CYC(HOLD)) dut (
    .ref_clk_i    (clk),
    .glob_arst_ni (rstn),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s at edge %0d: got %b want %b", name, cyc, got, want);
    end
  endtask

  task automatic chk_b(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s at edge %0d: got %b want %b", name, cyc, got, want);
    end
  endtask

  // Model: mode 0 idle, 1 sequencing/run (timeline from t0), 2 flush (from edge f)
  int            mode = 0;
  int            t0   = 0;
  int            s    = 1;
  int            f    = 0;
  int            rel [N];
  logic [N-1:0]  exp_clk   = '0;
  logic [N-1:0]  exp_rst   = '0;
  logic [N-1:0]  flush_clk = '0;
  logic          exp_busy  = 1'b0;
  logic          exp_done  = 1'b0;

  initial begin
    for (int k = 0; k < N; k++) rel[k] = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rstn !== 1'b1) begin
        mode = 0;
        exp_clk = '0; exp_rst = '0; exp_busy = 1'b0; exp_done = 1'b0;
      end else if (mode == 0) begin
        exp_clk = '0; exp_rst = '0; exp_busy = 1'b0; exp_done = 1'b0;
        if (bus.en_i) begin
          mode = 1;
          t0   = cyc;
          s    = (bus.stagger_i == 8'd0) ? 1 : int'(bus.stagger_i);
          for (int k = 0; k < N; k++) rel[k] = 0;
        end
      end else if (mode == 1) begin
        for (int k = 0; k < N; k++) begin
          exp_clk[k] = (cyc >= t0 + 1 + 2*k*s);
          exp_rst[k] = (cyc >= t0 + 1 + 2*k*s + s) && (cyc >= rel[k]);
        end
        exp_done = (cyc >= t0 + 1 + 2*N*s);
        exp_busy = !exp_done;
        if (!bus.en_i) begin
          mode      = 2;
          f         = cyc;
          flush_clk = exp_clk;
        end else if (cyc > t0 + 2*N*s) begin
          for (int k = 0; k < N; k++) begin
            if (bus.dom_req_i[k]) begin
              if (cyc < rel[k]) rel[k] = (rel[k] > cyc + 2) ? rel[k] : cyc + 2;
              else              rel[k] = cyc + HOLD + 1;
            end
          end
        end
      end else begin
        exp_clk = flush_clk; exp_rst = '0; exp_busy = 1'b1; exp_done = 1'b0;
        if (cyc == f + HOLD) mode = 0;
      end
      #1;
      chk("model_clk_en", bus.clk_en_o, exp_clk);
      chk("model_rst_n", bus.rst_no, exp_rst);
      chk_b("model_busy", bus.busy_o, exp_busy);
      chk_b("model_done", bus.done_o, exp_done);
    end
  end

  // Lands 2 time units after the requested edge
  task automatic goto_edge(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic goto_edge_toggle(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #2;
      bus.dom_req_i = 4'($urandom);
    end
  endtask

  int e0, p, fe, r, r2;

  initial begin
    rstn = 1'b0; bus.en_i = 1'b0; bus.stagger_i = 8'd0; bus.dom_req_i = 4'b0000;
    goto_edge(3);
    rstn = 1'b1;

    // Full sequence with S=4
    bus.stagger_i = 8'd4; bus.en_i = 1'b1; e0 = cyc + 1;
    goto_edge(e0 + 1);  chk("t1_clk_k0", bus.clk_en_o, 4'b0001); chk_b("t1_busy", bus.busy_o, 1'b1);
    goto_edge(e0 + 4);  chk("t1_rst_pre", bus.rst_no, 4'b0000);
    goto_edge(e0 + 5);  chk("t1_rst_k0", bus.rst_no, 4'b0001);
    goto_edge(e0 + 9);  chk("t1_clk_k1", bus.clk_en_o, 4'b0011);
    goto_edge(e0 + 17); chk("t1_clk_k2", bus.clk_en_o, 4'b0111);
    goto_edge(e0 + 24); chk("t1_clk_pre3", bus.clk_en_o, 4'b0111);
    goto_edge(e0 + 25); chk("t1_clk_k3", bus.clk_en_o, 4'b1111);
    goto_edge(e0 + 29); chk("t1_rst_k3", bus.rst_no, 4'b1111);
    goto_edge(e0 + 32); chk_b("t1_done_pre", bus.done_o, 1'b0);
    goto_edge(e0 + 33); chk_b("t1_done", bus.done_o, 1'b1); chk_b("t1_busy_run", bus.busy_o, 1'b0);

    // Soft reset: single-cycle and 10-cycle request on domain 2
    goto_edge(e0 + 36);
    bus.dom_req_i = 4'b0100; p = cyc + 1;
    goto_edge(p);      bus.dom_req_i = 4'b0000;
    goto_edge(p + 1);  chk("t3_rst_low", bus.rst_no, 4'b1011); chk("t3_clk", bus.clk_en_o, 4'b1111);
    goto_edge(p + 4);  chk("t3_rst_hold", bus.rst_no, 4'b1011);
    goto_edge(p + 5);  chk("t3_rst_rel", bus.rst_no, 4'b1111);
    goto_edge(p + 8);
    bus.dom_req_i = 4'b0100; p = cyc + 1;
    goto_edge(p + 9);  bus.dom_req_i = 4'b0000;
    goto_edge(p + 10); chk("t3_long_low", bus.rst_no, 4'b1011);
    goto_edge(p + 11); chk("t3_long_rel", bus.rst_no, 4'b1111);

    // en_i drop coinciding with a soft-reset request
    goto_edge(p + 14);
    bus.en_i = 1'b0; bus.dom_req_i = 4'b0001; fe = cyc + 1;
    goto_edge(fe + 1); chk("t5_rst", bus.rst_no, 4'b0000); chk("t5_clk", bus.clk_en_o, 4'b1111);
    chk_b("t5_busy", bus.busy_o, 1'b1); chk_b("t5_done", bus.done_o, 1'b0);
    goto_edge(fe + 4); chk("t5_clk_hold", bus.clk_en_o, 4'b1111);
    goto_edge(fe + 5); chk("t5_clk_off", bus.clk_en_o, 4'b0000); chk_b("t5_busy_off", bus.busy_o, 1'b0);
    bus.dom_req_i = 4'b0000;

    // stagger 0 behaves as 1
    goto_edge(fe + 6);
    bus.stagger_i = 8'd0; bus.en_i = 1'b1; e0 = cyc + 1;
    goto_edge(e0 + 7); chk("t2_rst_pre", bus.rst_no, 4'b0111);
    goto_edge(e0 + 8); chk("t2_rst_k3", bus.rst_no, 4'b1111); chk_b("t2_done_pre", bus.done_o, 1'b0);
    goto_edge(e0 + 9); chk_b("t2_done", bus.done_o, 1'b1);

    // Shutdown during RST_OFF(1) with dom_req_i toggling; en_i re-raised inside FLUSH
    goto_edge(e0 + 10);
    bus.en_i = 1'b0; fe = cyc + 1;
    goto_edge(fe + HOLD + 1);
    bus.stagger_i = 8'd4; bus.en_i = 1'b1; e0 = cyc + 1;
    goto_edge_toggle(e0 + 13);
    bus.en_i = 1'b0; fe = cyc + 1;
    goto_edge_toggle(fe + 1); chk("t4_rst", bus.rst_no, 4'b0000); chk("t4_clk", bus.clk_en_o, 4'b0011);
    goto_edge_toggle(fe + 2); bus.en_i = 1'b1;
    goto_edge_toggle(fe + 4); chk("t4_clk_hold", bus.clk_en_o, 4'b0011);
    goto_edge_toggle(fe + 5); chk("t4_clk_off", bus.clk_en_o, 4'b0000);
    goto_edge_toggle(fe + 6); chk("t4_restart", bus.clk_en_o, 4'b0001);
    bus.dom_req_i = 4'b0000;

    // Global reset mid-sequence, then in RUN; restart with fresh stagger
    goto_edge(fe + 5 + 9);
    rstn = 1'b0; bus.stagger_i = 8'd2; r = cyc + 1;
    goto_edge(r); chk("t6_clk", bus.clk_en_o, 4'b0000); chk("t6_rst", bus.rst_no, 4'b0000);
    chk_b("t6_busy", bus.busy_o, 1'b0);
    rstn = 1'b1;
    goto_edge(r + 2); chk("t6_reseq", bus.clk_en_o, 4'b0001);
    goto_edge(r + 3); chk("t6_rst_pre", bus.rst_no, 4'b0000);
    goto_edge(r + 4); chk("t6_rst_k0", bus.rst_no, 4'b0001);
    goto_edge(r + 20);
    rstn = 1'b0; bus.stagger_i = 8'd3; r2 = cyc + 1;
    goto_edge(r2); chk_b("t6_run_done", bus.done_o, 1'b0); chk("t6_run_clk", bus.clk_en_o, 4'b0000);
    rstn = 1'b1;
    goto_edge(r2 + 2); chk("t6_run_reseq", bus.clk_en_o, 4'b0001);
    goto_edge(r2 + 5); chk("t6_run_rst_k0", bus.rst_no, 4'b0001);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      goto_edge(cyc + 1);
      if (bus.en_i) bus.en_i = ($urandom_range(0, 119) != 0);
      else          bus.en_i = ($urandom_range(0, 7) == 0);
      bus.stagger_i = 8'($urandom_range(0, 5));
      for (int k = 0; k < N; k++)
        bus.dom_req_i[k] = (bus.dom_req_i[k] && ($urandom_range(0, 3) != 0)) || ($urandom_range(0, 19) == 0);
      rstn = ($urandom_range(0, 499) != 0);
    end
    rstn = 1'b1;
    goto_edge(cyc + 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
